// File: rtl/pwm_pkg.sv
// Shared types and constants for the center-aligned PWM block.
// Carrier direction encoding and default counter width.
package pwm_pkg;

   localparam int PWM_WIDTH_DEFAULT = 4;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage : pwm_pkg

// File: rtl/pwm_tri_counter.sv
// Triangle carrier: WIDTH-bit up/down counter, 0..MAX..1, period 2*MAX clocks.
// Turn points never repeat a value; period_start flags every valley (cnt == 0).
module pwm_tri_counter
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] cnt,
   output dir_e             dir,
   output logic             period_start
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // NOTE: non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         dir <= DIR_UP;
      end else begin
         unique case (dir)
            DIR_UP: begin
               if (cnt == CNT_MAX) begin
                  dir <= DIR_DOWN;
                  cnt <= CNT_MAX - CNT_ONE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DIR_DOWN: begin
               if (cnt == '0) begin
                  dir <= DIR_UP;
                  cnt <= CNT_ONE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               dir <= DIR_UP;
               cnt <= '0;
            end
         endcase
      end
   end

   // The first edge after reset (cnt == 0, UP) is also a period start.
   assign period_start = (cnt == '0);

endmodule : pwm_tri_counter

// File: rtl/pwm_up_down.sv
// Center-aligned PWM: registered compare of the triangle carrier against a
// duty code latched at each valley. Optional input synchronizer: PWM_IN_SYNC_EN.
module pwm_up_down
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] PWM_in,
   output logic             PWM_out
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] cnt;
   dir_e             dir;
   logic             period_start;
   logic [WIDTH-1:0] duty_in;
   logic [WIDTH-1:0] duty_q;
   logic [WIDTH-1:0] duty_eff;

   pwm_tri_counter #(
      .WIDTH(WIDTH)
   ) u_carrier (
      .clk         (clk),
      .rst_n       (rst_n),
      .cnt         (cnt),
      .dir         (dir),
      .period_start(period_start)
   );

`ifdef PWM_IN_SYNC_EN
   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= PWM_in;
         sync_q2 <= sync_q1;
      end
   end

   assign duty_in = sync_q2;
`else
   assign duty_in = PWM_in;
`endif

   // At the valley the freshly latched code already governs this edge's compare.
   assign duty_eff = period_start ? duty_in : duty_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q  <= '0;
         PWM_out <= 1'b0;
      end else begin
         if (period_start) begin
            duty_q <= duty_in;
         end
         PWM_out <= (cnt < duty_eff);
      end
   end

   a_turn_at_peak : assert property (
      @(posedge clk) disable iff (!rst_n)
      (dir == DIR_UP && cnt == CNT_MAX) |=> (dir == DIR_DOWN)
   );

endmodule : pwm_up_down

// File: tb/tb_pwm_up_down.sv
// Self-checking bench for pwm_up_down: period-indexed reference model checked
// every cycle, plus literal per-period high-time and centering expectations.
module tb_pwm_up_down;
   import pwm_pkg::*;

   localparam int WIDTH  = 4;
   localparam int MAX    = 15;
   localparam int PERIOD = 30;

`ifdef PWM_IN_SYNC_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic [WIDTH-1:0] PWM_in = '0;
   logic             PWM_out;

   int checks = 0;
   int errors = 0;

   always #20 clk = ~clk;

   pwm_up_down #(
      .WIDTH(WIDTH)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .PWM_in (PWM_in),
      .PWM_out(PWM_out)
   );

   // Carrier value at a given clock index since reset release.
   function automatic int tri_at(input int k);
      int p;
      p = k % PERIOD;
      return (p <= MAX) ? p : PERIOD - p;
   endfunction

   function automatic bit symmetric(input logic [PERIOD-1:0] b);
      bit ok;
      ok = 1'b1;
      for (int i = 1; i < MAX; i++) begin
         if (b[i] !== b[PERIOD-i]) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: clock index m_k, duty captured at each period start,
   // output = carrier position below duty, one clock late.
   int          m_k    = 0;
   int          m_duty = 0;
   logic        m_out  = 1'b0;
   logic [3:0]  m_h1   = '0;
   logic [3:0]  m_h2   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_k    = 0;
         m_duty = 0;
         m_out  = 1'b0;
         m_h1   = '0;
         m_h2   = '0;
      end else begin
         int in_eff;
         in_eff = SYNC ? int'(m_h2) : int'(PWM_in);
         m_h2   = m_h1;
         m_h1   = PWM_in;
         if (m_k % PERIOD == 0) m_duty = in_eff;
         m_out = (tri_at(m_k) < m_duty);
         m_k++;
      end
   end

   always @(negedge clk) begin
      if (rst_n !== 1'bx) begin
         check("model_pwm_out", PWM_out, m_out);
         check("model_cnt", u_dut.cnt, tri_at(m_k));
      end
   end

   // Capture one full period of PWM_out, aligned to the output of the valley
   // clock. Optionally changes PWM_in at window index change_at.
   task automatic measure(input int change_at, input logic [3:0] new_val,
                          output logic [PERIOD-1:0] bits);
      int n;
      n    = 0;
      bits = '0;
      do begin
         @(negedge clk);
         n++;
      end while (m_k % PERIOD != 1 && n < 64);
      if (n >= 64) begin
         checks++;
         errors++;
         $display("FAIL align_timeout: got %0d clocks expected < 64", n);
         return;
      end
      for (int i = 0; i < PERIOD; i++) begin
         bits[i] = PWM_out;
         if (i == change_at) PWM_in = new_val;
         if (i < PERIOD - 1) @(negedge clk);
      end
   endtask

   initial begin
      #(40 * 5000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [PERIOD-1:0] b;
      int n;

      PWM_in = 4'd10;
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_out", PWM_out, 0);
      check("rst_async_cnt", u_dut.cnt, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // First period after reset: duty latched on the very first edge.
      measure(-1, 4'd0, b);
      check("first_period_highs", $countones(b), SYNC ? 0 : 19);

      // Duty 10, then 10->3 on the edge where cnt == 7.
      measure(6, 4'd3, b);
      check("duty10_highs", $countones(b), 19);
      check("duty10_centered", symmetric(b), 1);
      check("duty10_valley_high", b[0], 1);
      check("duty10_peak_low", b[MAX], 0);
      measure(-1, 4'd0, b);
      check("duty3_after_change_highs", $countones(b), 5);
      check("duty3_centered", symmetric(b), 1);

      PWM_in = 4'd15;
      measure(-1, 4'd0, b);
      measure(-1, 4'd0, b);
      check("duty15_highs", $countones(b), 29);
      check("duty15_low_after_peak", b[MAX], 0);
      check("duty15_centered", symmetric(b), 1);

      PWM_in = 4'd0;
      measure(-1, 4'd0, b);
      measure(-1, 4'd0, b);
      check("duty0_highs", $countones(b), 0);

      PWM_in = 4'd3;
      measure(-1, 4'd0, b);
      measure(-1, 4'd0, b);
      check("duty3_highs", $countones(b), 5);

      // Change one clock before the period-start edge.
      PWM_in = 4'd7;
      measure(-1, 4'd0, b);
      check("late_change_period", $countones(b), SYNC ? 5 : 13);
      measure(-1, 4'd0, b);
      check("late_change_next", $countones(b), 13);

      // Reset while the output is high, at a random phase inside the clock.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (PWM_out !== 1'b1 && n < 64);
      check("wait_high_before_reset", PWM_out, 1);
      #($urandom_range(15, 1));
      rst_n = 1'b0;
      #1;
      check("midrun_rst_out", PWM_out, 0);
      check("midrun_rst_cnt", u_dut.cnt, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("release_cnt", u_dut.cnt, 0);
      measure(-1, 4'd0, b);
      check("post_reset_period", $countones(b), SYNC ? 0 : 13);
      measure(-1, 4'd0, b);
      check("post_reset_next", $countones(b), 13);
      check("post_reset_centered", symmetric(b), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pwm_up_down

// File: doc/pwm_up_down.md
PWM_UP_DOWN -- requirements
Module: pwm_up_down

Interface
REQ-001 SHALL have parameter WIDTH, default 4, duty and counter bit width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port PWM_in  input  WIDTH  requested duty code, 0..2^WIDTH-1.
REQ-005 SHALL have port PWM_out  output  1  registered center-aligned PWM waveform.
REQ-006 SHALL use one clock (clk) with an asynchronous, active-low reset (rst_n).

Function
REQ-007 SHALL contain a WIDTH-bit up/down counter cnt and a direction flag dir (UP/DOWN), forming a triangle carrier.
REQ-008 SHALL step cnt 0,1,...,MAX,MAX-1,...,1,0,1,... with MAX = 2^WIDTH-1, so one period is 2*MAX clocks (30 at WIDTH=4).
REQ-009 SHALL, at cnt==MAX while UP, switch to DOWN and load cnt=MAX-1; at cnt==0 while DOWN, switch to UP and load cnt=1. No value repeats at either turn point.
REQ-010 SHALL latch duty_q <= effective PWM_in on every edge where cnt==0 (period start); PWM_in changes mid-period SHALL NOT affect the current period.
REQ-011 SHALL update PWM_out on every edge as (cnt < duty_eff), with duty_eff = latched-in value when cnt==0, else duty_q. PWM_out lags the counter by one clock.
REQ-012 SHALL produce high time per period of 0 cycles for duty 0, 2*duty-1 cycles for 1<=duty<=MAX (19 of 30 for duty 10, 29 of 30 for duty 15).
REQ-013 SHALL center the high pulse on the counter valley (cnt==0); the output is symmetric about it.
REQ-014 SHALL perform all compares unsigned at WIDTH bits; no overflow or wrap beyond the turn rules.

Reset
REQ-015 SHALL, while rst_n==0, force cnt=0, dir=UP, duty_q=0, PWM_out=0 immediately, independent of clk.
REQ-016 SHALL, on the first rising edge after rst_n deasserts, treat cnt==0 as period start and latch PWM_in.
REQ-017 SHALL, on reset asserted mid-period, abandon the period; no partial pulse completes.

Configuration
REQ-018 SHALL, when macro PWM_IN_SYNC_EN is defined, pass PWM_in through a two-stage register synchronizer (reset to 0) before the duty latch, adding 2 clocks of input latency.
REQ-019 SHALL, without PWM_IN_SYNC_EN, feed PWM_in directly to the duty latch.

Structure
REQ-020 SHALL place the dir encoding (UP/DOWN typedef) and default WIDTH constant in shared package pwm_pkg.
REQ-021 SHALL implement the carrier as sub-module pwm_tri_counter (outputs cnt, dir, period-start strobe); compare and duty latch stay in the top.

Verification
REQ-022 SHALL cover reset: rst_n=0 for 3 clocks at random phase -> PWM_out=0, cnt=0 throughout.
REQ-023 SHALL cover steady duty: PWM_in=10, clk period 40 ns -> every 30-clock period has exactly 19 high clocks, pulse centered on cnt==0.
REQ-024 SHALL cover extremes: PWM_in=0 -> PWM_out never high; PWM_in=15 -> high 29 of 30 clocks, low only the clock after cnt==MAX.
REQ-025 SHALL cover mid-period change: PWM_in 10->3 at cnt==7 rising -> current period keeps 19 high clocks, next period has 5.
REQ-026 SHALL cover reset mid-operation: assert rst_n while PWM_out=1 -> PWM_out falls asynchronously; after release, counter restarts at 0.
REQ-027 SHALL cover PWM_IN_SYNC_EN: PWM_in change 1 clock before period start -> not applied until the following period; without macro, applied at that start.
